// File: rtl/mic_level_scheduler.sv
// rtl/mic_level_scheduler.sv - per-frame mic level: windowed peak with hold/decay, or raw sample
// Output changes only on frame_begin so the OLED renderer never sees a mid-frame change.
module mic_level_scheduler #(
  parameter int WINDOW      = 2000,
  parameter int HOLD_FRAMES = 8,
  parameter int DECAY_STEP  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [11:0] mic_data,
  input  logic        frame_begin,
  input  logic        bar_mode,
  input  logic        freeze,
  output logic [11:0] disp_data,
  output logic        disp_update,
  output logic        peak_flag
);

  localparam int CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WINDOW - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);
  localparam logic [11:0]   STEP      = 12'(DECAY_STEP);

  typedef enum logic [1:0] {HOLD, DECAY, FROZEN} state_t;

  state_t        state;
  state_t        saved_state;
  logic [11:0]   acc;
  logic [CW-1:0] cnt;
  logic [11:0]   held;
  logic [HW-1:0] hold_cnt;
  logic [11:0]   last_sample;

  logic          win_done;
  logic [11:0]   win_peak;

  assign win_peak  = (mic_data > acc) ? mic_data : acc;
  assign win_done  = sample_en && (cnt == CNT_LAST);
  assign peak_flag = (state == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= DECAY;
      saved_state <= DECAY;
      acc         <= '0;
      cnt         <= '0;
      held        <= '0;
      hold_cnt    <= '0;
      last_sample <= '0;
      disp_data   <= '0;
      disp_update <= 1'b0;
    end else begin
      disp_update <= 1'b0;

      // The window keeps running while frozen; only its result is discarded.
      if (sample_en) begin
        last_sample <= mic_data;
        if (win_done) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= win_peak;
          cnt <= cnt + 1'b1;
        end
      end

      if (frame_begin && state != FROZEN && !freeze) begin
        disp_data   <= bar_mode ? held : last_sample;
        disp_update <= 1'b1;
      end

      case (state)
        FROZEN: begin
          if (!freeze) state <= saved_state;
        end
        default: begin
          if (freeze) begin
            saved_state <= state;
            state       <= FROZEN;
          end else if (win_done && win_peak >= held) begin
            held     <= win_peak;
            hold_cnt <= HOLD_INIT;
            state    <= HOLD;
          end else if (frame_begin) begin
            if (state == HOLD) begin
              hold_cnt <= hold_cnt - 1'b1;
              if (hold_cnt == HW'(1)) state <= DECAY;
            end else begin
              held <= (held > STEP) ? held - STEP : 12'd0;
            end
          end
        end
      endcase
    end
  end

endmodule
